// File: rtl/ysyx_22041211_ifu_prefetch_pkg.sv
// Shared encodings for the prefetching instruction fetch unit.
package ysyx_22041211_ifu_prefetch_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    REQ  = 2'b01,
    RESP = 2'b10
  } ifu_state_e;

  localparam logic [1:0]  AXI_RESP_OKAY    = 2'b00;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;

endpackage

// File: rtl/ysyx_22041211_sync_fifo.sv
// Synchronous FIFO with flush; storage is not reset, only the pointers/count.
module ysyx_22041211_sync_fifo #(
  parameter int WIDTH = 65,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  // entry storage
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= din;
    end
  end

  // pointers and occupancy; flush drops everything at once
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  assign dout  = mem[rd_ptr];
  assign empty = (count == '0);
  assign full  = (count == DEPTH_C);

endmodule

// File: rtl/ysyx_22041211_ifu_prefetch.sv
// Instruction fetch unit: sequential prefetch over AXI-lite AR/R into a FIFO
// feeding the IDU, with redirect flush and stale-response discard.
module ysyx_22041211_ifu_prefetch
  import ysyx_22041211_ifu_prefetch_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = ADDR_WIDTH'(RESET_PC_DEFAULT)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  branch_flag_i,
  input  logic [ADDR_WIDTH-1:0] branch_target_i,
  input  logic                  jmp_flag_i,
  input  logic [ADDR_WIDTH-1:0] jmp_target_i,
  input  logic                  csr_jmp_i,
  input  logic [ADDR_WIDTH-1:0] csr_pc_i,
  output logic                  inst_valid_o,
  input  logic                  inst_ready_i,
  output logic [DATA_WIDTH-1:0] inst_o,
  output logic [ADDR_WIDTH-1:0] pc_o,
  output logic                  inst_err_o,
  output logic                  addr_r_valid_o,
  input  logic                  addr_r_ready_i,
  output logic [ADDR_WIDTH-1:0] addr_r_addr_o,
  input  logic [DATA_WIDTH-1:0] r_data_i,
  input  logic [1:0]            r_resp_i,
  input  logic                  r_valid_i,
  output logic                  r_ready_o
);

  localparam int ENTRY_W = ADDR_WIDTH + DATA_WIDTH + 1;
  localparam int CNT_W   = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  ifu_state_e            state;
  ifu_state_e            state_nxt;
  logic [ADDR_WIDTH-1:0] fetch_pc;
  logic [ADDR_WIDTH-1:0] fetch_pc_nxt;
  logic [ADDR_WIDTH-1:0] ar_addr;
  logic [ADDR_WIDTH-1:0] redirect_pc;
  logic                  discard;
  logic                  discard_nxt;
  logic                  halted;
  logic                  halted_nxt;
  logic                  redirect;
  logic                  r_hs;
  logic                  resp_err;
  logic                  push;
  logic                  pop;
  logic [ENTRY_W-1:0]    push_entry;
  logic [ENTRY_W-1:0]    head_entry;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [CNT_W-1:0]      fifo_count;

  assign redirect = csr_jmp_i | jmp_flag_i | branch_flag_i;
  assign r_hs     = (state == RESP) && r_valid_i;
  assign resp_err = (r_resp_i != AXI_RESP_OKAY);
  // A response landing in the redirect cycle belongs to the old stream.
  assign push     = r_hs && !discard && !redirect && !fifo_full;
  assign pop      = inst_valid_o && inst_ready_i && !redirect;
  assign push_entry = {fetch_pc, r_data_i, resp_err};

  // redirect target: trap/mret over jump over branch
  always_comb begin
    redirect_pc = branch_target_i;
    if (csr_jmp_i) begin
      redirect_pc = csr_pc_i;
    end else if (jmp_flag_i) begin
      redirect_pc = jmp_target_i;
    end
  end

  // fetch FSM next state and AXI channel handshake outputs
  always_comb begin
    state_nxt      = state;
    addr_r_valid_o = 1'b0;
    r_ready_o      = 1'b0;
    unique case (state)
      IDLE: begin
        // a request is only issued with a free slot, so its push cannot overflow
        if (!halted && (fifo_count < DEPTH_C)) begin
          state_nxt = REQ;
        end
      end
      REQ: begin
        addr_r_valid_o = 1'b1;
        if (addr_r_ready_i) begin
          state_nxt = RESP;
        end
      end
      RESP: begin
        r_ready_o = 1'b1;
        if (r_valid_i) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // fetch pointer, stale-response discard and error halt bookkeeping
  always_comb begin
    fetch_pc_nxt = fetch_pc;
    discard_nxt  = discard;
    halted_nxt   = halted;
    if (r_hs) begin
      discard_nxt = 1'b0;
    end
    if (push) begin
      fetch_pc_nxt = fetch_pc + ADDR_WIDTH'(4);
      if (resp_err) begin
        halted_nxt = 1'b1;
      end
    end
    if (redirect) begin
      fetch_pc_nxt = redirect_pc;
      halted_nxt   = 1'b0;
      // the in-flight request (not yet answered) must have its response dropped
      if ((state == REQ) || ((state == RESP) && !r_hs)) begin
        discard_nxt = 1'b1;
      end
    end
  end

  // control state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      fetch_pc <= RESET_PC;
      discard  <= 1'b0;
      halted   <= 1'b0;
    end else begin
      state    <= state_nxt;
      fetch_pc <= fetch_pc_nxt;
      discard  <= discard_nxt;
      halted   <= halted_nxt;
    end
  end

  // ARADDR is captured at issue so it holds steady through a redirect
  always_ff @(posedge clk) begin
    if ((state == IDLE) && (state_nxt == REQ)) begin
      ar_addr <= fetch_pc_nxt;
    end
  end

  assign addr_r_addr_o = (state == REQ) ? ar_addr : '0;

  ysyx_22041211_sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .flush (redirect),
    .din   (push_entry),
    .dout  (head_entry),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign inst_valid_o = !fifo_empty;
  assign pc_o         = head_entry[ENTRY_W-1 -: ADDR_WIDTH];
  assign inst_o       = head_entry[DATA_WIDTH:1];
  assign inst_err_o   = head_entry[0];

endmodule

// File: tb/tb_ysyx_22041211_ifu_prefetch.sv
// Directed bench for the prefetching IFU with a small AXI-lite read slave.
module tb_ysyx_22041211_ifu_prefetch;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        err;
  } deliv_t;

  logic        clk;
  logic        rst;
  logic        branch_flag_i;
  logic [31:0] branch_target_i;
  logic        jmp_flag_i;
  logic [31:0] jmp_target_i;
  logic        csr_jmp_i;
  logic [31:0] csr_pc_i;
  logic        inst_valid_o;
  logic        inst_ready_i;
  logic [31:0] inst_o;
  logic [31:0] pc_o;
  logic        inst_err_o;
  logic        addr_r_valid_o;
  logic        addr_r_ready_i;
  logic [31:0] addr_r_addr_o;
  logic [31:0] r_data_i;
  logic [1:0]  r_resp_i;
  logic        r_valid_i;
  logic        r_ready_o;

  // slave configuration
  int          r_delay;
  logic        err_en;
  logic [31:0] err_addr;
  logic        s_pend;
  int          s_cnt;
  logic [31:0] s_addr;

  logic [31:0] arq[$];
  deliv_t      dq[$];

  int cmp_cnt;
  int fail_cnt;

  ysyx_22041211_ifu_prefetch dut (
    .clk             (clk),
    .rst             (rst),
    .branch_flag_i   (branch_flag_i),
    .branch_target_i (branch_target_i),
    .jmp_flag_i      (jmp_flag_i),
    .jmp_target_i    (jmp_target_i),
    .csr_jmp_i       (csr_jmp_i),
    .csr_pc_i        (csr_pc_i),
    .inst_valid_o    (inst_valid_o),
    .inst_ready_i    (inst_ready_i),
    .inst_o          (inst_o),
    .pc_o            (pc_o),
    .inst_err_o      (inst_err_o),
    .addr_r_valid_o  (addr_r_valid_o),
    .addr_r_ready_i  (addr_r_ready_i),
    .addr_r_addr_o   (addr_r_addr_o),
    .r_data_i        (r_data_i),
    .r_resp_i        (r_resp_i),
    .r_valid_i       (r_valid_i),
    .r_ready_o       (r_ready_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // memory contents: word at address a is ~a
  assign r_valid_i = s_pend && (s_cnt == 0);
  assign r_data_i  = ~s_addr;
  assign r_resp_i  = (err_en && (s_addr == err_addr)) ? 2'b10 : 2'b00;

  always @(posedge clk) begin
    if (rst) begin
      s_pend <= 1'b0;
      s_cnt  <= 0;
    end else if (addr_r_valid_o && addr_r_ready_i) begin
      s_pend <= 1'b1;
      s_cnt  <= r_delay;
      s_addr <= addr_r_addr_o;
    end else if (s_pend && (s_cnt != 0)) begin
      s_cnt <= s_cnt - 1;
    end else if (s_pend && r_ready_o) begin
      s_pend <= 1'b0;
    end
  end

  // record AR handshakes and accepted (non-flushed) deliveries
  always @(posedge clk) begin
    if (!rst) begin
      if (addr_r_valid_o && addr_r_ready_i) arq.push_back(addr_r_addr_o);
      if (inst_valid_o && inst_ready_i && !(csr_jmp_i || jmp_flag_i || branch_flag_i))
        dq.push_back('{pc: pc_o, inst: inst_o, err: inst_err_o});
    end
  end

  function automatic logic [31:0] ar_at(int i);
    if (i < arq.size()) return arq[i];
    return 32'hDEAD_DEAD;
  endfunction

  function automatic deliv_t d_at(int i);
    deliv_t d;
    d = '{pc: 32'hDEAD_BEEF, inst: 32'hDEAD_BEEF, err: 1'bx};
    if (i < dq.size()) d = dq[i];
    return d;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    branch_flag_i = 1'b0;
    jmp_flag_i = 1'b0;
    csr_jmp_i = 1'b0;
    repeat (2) @(negedge clk);
    arq.delete();
    dq.delete();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    addr_r_ready_i = 1'b0;
    inst_ready_i = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    cmp_cnt++; if (inst_valid_o !== 1'b0) begin fail_cnt++; $display("FAIL rst_inst_valid: got %b expected 0", inst_valid_o); end
    cmp_cnt++; if (addr_r_valid_o !== 1'b0) begin fail_cnt++; $display("FAIL rst_arvalid: got %b expected 0", addr_r_valid_o); end
    cmp_cnt++; if (r_ready_o !== 1'b0) begin fail_cnt++; $display("FAIL rst_rready: got %b expected 0", r_ready_o); end
    cmp_cnt++; if (addr_r_addr_o !== 32'h0) begin fail_cnt++; $display("FAIL rst_araddr: got %h expected 0", addr_r_addr_o); end
    rst = 1'b0;
    @(negedge clk);
    cmp_cnt++; if (addr_r_valid_o !== 1'b1) begin fail_cnt++; $display("FAIL first_arvalid: got %b expected 1", addr_r_valid_o); end
    cmp_cnt++; if (addr_r_addr_o !== 32'h8000_0000) begin fail_cnt++; $display("FAIL first_araddr: got %h expected 80000000", addr_r_addr_o); end
    @(negedge clk);
    cmp_cnt++; if (addr_r_valid_o !== 1'b1 || addr_r_addr_o !== 32'h8000_0000) begin fail_cnt++; $display("FAIL ar_hold: got %b/%h expected 1/80000000", addr_r_valid_o, addr_r_addr_o); end
  endtask

  task automatic test_streaming();
    r_delay = 0; err_en = 1'b0;
    addr_r_ready_i = 1'b1; inst_ready_i = 1'b1;
    do_reset();
    repeat (20) @(negedge clk);
    cmp_cnt++; if (d_at(0).pc !== 32'h8000_0000) begin fail_cnt++; $display("FAIL stream_pc0: got %h expected 80000000", d_at(0).pc); end
    cmp_cnt++; if (d_at(1).pc !== 32'h8000_0004) begin fail_cnt++; $display("FAIL stream_pc1: got %h expected 80000004", d_at(1).pc); end
    cmp_cnt++; if (d_at(2).pc !== 32'h8000_0008) begin fail_cnt++; $display("FAIL stream_pc2: got %h expected 80000008", d_at(2).pc); end
    cmp_cnt++; if (d_at(0).inst !== 32'h7FFF_FFFF) begin fail_cnt++; $display("FAIL stream_inst0: got %h expected 7fffffff", d_at(0).inst); end
    cmp_cnt++; if (d_at(1).inst !== 32'h7FFF_FFFB) begin fail_cnt++; $display("FAIL stream_inst1: got %h expected 7ffffffb", d_at(1).inst); end
    cmp_cnt++; if (d_at(2).inst !== 32'h7FFF_FFF7) begin fail_cnt++; $display("FAIL stream_inst2: got %h expected 7ffffff7", d_at(2).inst); end
    cmp_cnt++; if ({d_at(0).err, d_at(1).err, d_at(2).err} !== 3'b000) begin fail_cnt++; $display("FAIL stream_err: got %b%b%b expected 000", d_at(0).err, d_at(1).err, d_at(2).err); end
  endtask

  task automatic test_back_pressure();
    r_delay = 0; err_en = 1'b0;
    addr_r_ready_i = 1'b1; inst_ready_i = 1'b0;
    do_reset();
    repeat (30) @(negedge clk);
    cmp_cnt++; if (arq.size() !== 4) begin fail_cnt++; $display("FAIL bp_ar_count: got %0d expected 4", arq.size()); end
    cmp_cnt++; if (addr_r_valid_o !== 1'b0) begin fail_cnt++; $display("FAIL bp_arvalid: got %b expected 0", addr_r_valid_o); end
    cmp_cnt++; if (inst_valid_o !== 1'b1 || pc_o !== 32'h8000_0000) begin fail_cnt++; $display("FAIL bp_head: got %b/%h expected 1/80000000", inst_valid_o, pc_o); end
    cmp_cnt++; if (inst_o !== 32'h7FFF_FFFF) begin fail_cnt++; $display("FAIL bp_head_inst: got %h expected 7fffffff", inst_o); end
    inst_ready_i = 1'b1;
    repeat (10) @(negedge clk);
    cmp_cnt++; if (ar_at(4) !== 32'h8000_0010) begin fail_cnt++; $display("FAIL bp_resume_ar: got %h expected 80000010", ar_at(4)); end
    cmp_cnt++; if (d_at(3).pc !== 32'h8000_000C) begin fail_cnt++; $display("FAIL bp_pc3: got %h expected 8000000c", d_at(3).pc); end
  endtask

  task automatic test_redirect_resp();
    int n;
    r_delay = 3; err_en = 1'b0;
    addr_r_ready_i = 1'b1; inst_ready_i = 1'b1;
    do_reset();
    n = 0;
    while (r_ready_o !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    cmp_cnt++; if (n >= 20) begin fail_cnt++; $display("FAIL redir_wait_resp: got timeout expected RRESP state"); end
    jmp_flag_i = 1'b1; jmp_target_i = 32'h8000_0100;
    @(negedge clk);
    jmp_flag_i = 1'b0;
    cmp_cnt++; if (inst_valid_o !== 1'b0) begin fail_cnt++; $display("FAIL redir_empty: got %b expected 0", inst_valid_o); end
    cmp_cnt++; if (r_ready_o !== 1'b1) begin fail_cnt++; $display("FAIL redir_still_resp: got %b expected 1", r_ready_o); end
    repeat (25) @(negedge clk);
    cmp_cnt++; if (ar_at(1) !== 32'h8000_0100) begin fail_cnt++; $display("FAIL redir_ar1: got %h expected 80000100", ar_at(1)); end
    cmp_cnt++; if (d_at(0).pc !== 32'h8000_0100) begin fail_cnt++; $display("FAIL redir_pc0: got %h expected 80000100", d_at(0).pc); end
    cmp_cnt++; if (d_at(0).inst !== 32'h7FFF_FEFF) begin fail_cnt++; $display("FAIL redir_inst0: got %h expected 7ffffeff", d_at(0).inst); end
  endtask

  task automatic test_simul_redirect();
    int n;
    r_delay = 0; err_en = 1'b0;
    addr_r_ready_i = 1'b1; inst_ready_i = 1'b1;
    do_reset();
    n = 0;
    while (!(r_ready_o === 1'b1 && r_valid_i === 1'b1) && n < 20) begin @(negedge clk); n++; end
    cmp_cnt++; if (n >= 20) begin fail_cnt++; $display("FAIL simul_wait_r: got timeout expected R handshake"); end
    csr_jmp_i = 1'b1; csr_pc_i = 32'h8000_0200;
    branch_flag_i = 1'b1; branch_target_i = 32'h8000_0300;
    @(negedge clk);
    csr_jmp_i = 1'b0; branch_flag_i = 1'b0;
    cmp_cnt++; if (inst_valid_o !== 1'b0) begin fail_cnt++; $display("FAIL simul_no_push: got %b expected 0", inst_valid_o); end
    repeat (20) @(negedge clk);
    cmp_cnt++; if (ar_at(1) !== 32'h8000_0200) begin fail_cnt++; $display("FAIL simul_ar1: got %h expected 80000200", ar_at(1)); end
    cmp_cnt++; if (ar_at(2) !== 32'h8000_0204) begin fail_cnt++; $display("FAIL simul_ar2: got %h expected 80000204", ar_at(2)); end
    cmp_cnt++; if (d_at(0).pc !== 32'h8000_0200) begin fail_cnt++; $display("FAIL simul_pc0: got %h expected 80000200", d_at(0).pc); end
    cmp_cnt++; if (d_at(0).inst !== 32'h7FFF_FDFF) begin fail_cnt++; $display("FAIL simul_inst0: got %h expected 7ffffdff", d_at(0).inst); end
  endtask

  task automatic test_error();
    r_delay = 0; err_en = 1'b1; err_addr = 32'h8000_0008;
    addr_r_ready_i = 1'b1; inst_ready_i = 1'b1;
    do_reset();
    repeat (25) @(negedge clk);
    cmp_cnt++; if (arq.size() !== 3) begin fail_cnt++; $display("FAIL err_ar_count: got %0d expected 3", arq.size()); end
    cmp_cnt++; if (dq.size() !== 3) begin fail_cnt++; $display("FAIL err_deliv_count: got %0d expected 3", dq.size()); end
    cmp_cnt++; if (d_at(2).pc !== 32'h8000_0008 || d_at(2).err !== 1'b1) begin fail_cnt++; $display("FAIL err_entry: got %h/%b expected 80000008/1", d_at(2).pc, d_at(2).err); end
    cmp_cnt++; if (d_at(1).err !== 1'b0) begin fail_cnt++; $display("FAIL err_prev_ok: got %b expected 0", d_at(1).err); end
    cmp_cnt++; if (addr_r_valid_o !== 1'b0) begin fail_cnt++; $display("FAIL err_halted: got %b expected 0", addr_r_valid_o); end
    branch_flag_i = 1'b1; branch_target_i = 32'h8000_0040;
    @(negedge clk);
    branch_flag_i = 1'b0;
    repeat (15) @(negedge clk);
    cmp_cnt++; if (ar_at(3) !== 32'h8000_0040) begin fail_cnt++; $display("FAIL err_resume_ar: got %h expected 80000040", ar_at(3)); end
    cmp_cnt++; if (d_at(3).pc !== 32'h8000_0040 || d_at(3).err !== 1'b0) begin fail_cnt++; $display("FAIL err_resume_deliv: got %h/%b expected 80000040/0", d_at(3).pc, d_at(3).err); end
    err_en = 1'b0;
  endtask

  task automatic test_wrap();
    r_delay = 0; err_en = 1'b0;
    addr_r_ready_i = 1'b0; inst_ready_i = 1'b1;
    do_reset();
    @(negedge clk);
    branch_flag_i = 1'b1; branch_target_i = 32'hFFFF_FFFC;
    @(negedge clk);
    branch_flag_i = 1'b0;
    cmp_cnt++; if (addr_r_valid_o !== 1'b1 || addr_r_addr_o !== 32'h8000_0000) begin fail_cnt++; $display("FAIL wrap_ar_stable: got %b/%h expected 1/80000000", addr_r_valid_o, addr_r_addr_o); end
    addr_r_ready_i = 1'b1;
    repeat (20) @(negedge clk);
    cmp_cnt++; if (ar_at(1) !== 32'hFFFF_FFFC) begin fail_cnt++; $display("FAIL wrap_ar1: got %h expected fffffffc", ar_at(1)); end
    cmp_cnt++; if (ar_at(2) !== 32'h0000_0000) begin fail_cnt++; $display("FAIL wrap_ar2: got %h expected 00000000", ar_at(2)); end
    cmp_cnt++; if (d_at(0).pc !== 32'hFFFF_FFFC || d_at(0).inst !== 32'h0000_0003) begin fail_cnt++; $display("FAIL wrap_d0: got %h/%h expected fffffffc/00000003", d_at(0).pc, d_at(0).inst); end
    cmp_cnt++; if (d_at(1).pc !== 32'h0000_0000 || d_at(1).inst !== 32'hFFFF_FFFF) begin fail_cnt++; $display("FAIL wrap_d1: got %h/%h expected 00000000/ffffffff", d_at(1).pc, d_at(1).inst); end
  endtask

  task automatic test_reset_midreq();
    int n;
    r_delay = 0; err_en = 1'b0;
    addr_r_ready_i = 1'b1; inst_ready_i = 1'b0;
    do_reset();
    n = 0;
    while (!(inst_valid_o === 1'b1 && addr_r_valid_o === 1'b1) && n < 20) begin @(negedge clk); n++; end
    cmp_cnt++; if (n >= 20) begin fail_cnt++; $display("FAIL midreq_wait: got timeout expected REQ with entry"); end
    rst = 1'b1;
    @(negedge clk);
    cmp_cnt++; if (addr_r_valid_o !== 1'b0) begin fail_cnt++; $display("FAIL midreq_arvalid: got %b expected 0", addr_r_valid_o); end
    cmp_cnt++; if (inst_valid_o !== 1'b0) begin fail_cnt++; $display("FAIL midreq_empty: got %b expected 0", inst_valid_o); end
    arq.delete();
    dq.delete();
    inst_ready_i = 1'b1;
    rst = 1'b0;
    repeat (10) @(negedge clk);
    cmp_cnt++; if (ar_at(0) !== 32'h8000_0000) begin fail_cnt++; $display("FAIL midreq_restart_ar: got %h expected 80000000", ar_at(0)); end
    cmp_cnt++; if (d_at(0).pc !== 32'h8000_0000) begin fail_cnt++; $display("FAIL midreq_restart_pc: got %h expected 80000000", d_at(0).pc); end
  endtask

  initial begin
    cmp_cnt = 0;
    fail_cnt = 0;
    rst = 1'b1;
    branch_flag_i = 1'b0; branch_target_i = '0;
    jmp_flag_i = 1'b0; jmp_target_i = '0;
    csr_jmp_i = 1'b0; csr_pc_i = '0;
    inst_ready_i = 1'b0;
    addr_r_ready_i = 1'b0;
    r_delay = 0;
    err_en = 1'b0;
    err_addr = '0;
    repeat (2) @(negedge clk);
    test_reset();
    test_streaming();
    test_back_pressure();
    test_redirect_resp();
    test_simul_redirect();
    test_error();
    test_wrap();
    test_reset_midreq();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, fail_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected completion");
    $fatal(1, "timeout");
  end

endmodule
